// File: rtl/tpu_pkg.sv
// Shared widths, FSM state encoding and output framing constants for the
// systolic matrix-multiply unit.
package tpu_pkg;

    localparam int DATA_W    = 8;
    localparam int ACC_W     = 17;
    localparam int RES_W     = 16;
    localparam int OUT_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        OUTPUT,
        DONE
    } state_t;

endpackage

// File: rtl/systolic_pe.sv
// Weight-stationary processing element: holds one weight, multiply-adds the
// incoming activation into the partial sum and forwards both registered.
module systolic_pe
    import tpu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     w_load,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [ACC_W-1:0]  sum_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [ACC_W-1:0]  sum_out,
    output logic signed [ACC_W-1:0]  sum_nxt
);

    logic signed [DATA_W-1:0]   w_q;
    logic signed [2*DATA_W-1:0] prod;

    always_comb begin
        prod    = a_in * w_q;
        sum_nxt = sum_in + ACC_W'(prod);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q     <= '0;
            a_out   <= '0;
            sum_out <= '0;
        end else begin
            if (w_load)
                w_q <= w_in;
            if (clr) begin
                a_out   <= '0;
                sum_out <= '0;
            end else begin
                a_out   <= a_in;
                sum_out <= sum_nxt;
            end
        end
    end

endmodule

// File: rtl/systolic_mmu.sv
// 2x2 weight-stationary systolic multiply C = A*W with byte-serial result output.
// Build option: define SATURATE_EN to clamp column sums instead of wrapping them.
module systolic_mmu
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] weight_1,
    input  logic [DATA_W-1:0] weight_2,
    input  logic [DATA_W-1:0] weight_3,
    input  logic [DATA_W-1:0] weight_4,
    input  logic [DATA_W-1:0] mat_1,
    input  logic [DATA_W-1:0] mat_2,
    input  logic [DATA_W-1:0] mat_3,
    input  logic [DATA_W-1:0] mat_4,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    state_t                   state, state_nxt;
    logic [1:0]               cnt;
    logic [2:0]               idx;
    logic signed [DATA_W-1:0] mat_q [4];
    logic signed [DATA_W-1:0] feed_r0, feed_r1;
    logic signed [DATA_W-1:0] pe_a   [4];
    logic signed [ACC_W-1:0]  pe_sum [4];
    logic signed [ACC_W-1:0]  pe_nxt [4];
    logic signed [ACC_W-1:0]  col0_dly;
    logic [4*RES_W-1:0]       res_q, res_d;
    logic                     accept, last_step, pe_clr, w_load;

    function automatic logic [RES_W-1:0] reduce(input logic signed [ACC_W-1:0] s);
`ifdef SATURATE_EN
        if (s > 17'sd32767)
            return 16'h7FFF;
        else if (s < -17'sd32768)
            return 16'h8000;
        else
            return RES_W'(s);
`else
        return RES_W'(s);
`endif
    endfunction

    function automatic logic [7:0] pick(input logic [4*RES_W-1:0] r, input logic [2:0] i);
        return r[{~i, 3'b000} +: 8];
    endfunction

    assign accept    = out_valid && out_ready;
    assign last_step = (state == COMPUTE) && (cnt == 2'd3);
    assign pe_clr    = (state != COMPUTE);
    assign w_load    = (state == LOAD);

    // Row 0 takes a[i][0] at step i, row 1 takes a[i][1] one step later.
    always_comb begin
        feed_r0 = '0;
        feed_r1 = '0;
        case (cnt)
            2'd0: feed_r0 = mat_q[0];
            2'd1: begin
                feed_r0 = mat_q[2];
                feed_r1 = mat_q[1];
            end
            2'd2: feed_r1 = mat_q[3];
            default: ;
        endcase
    end

    systolic_pe u_pe00 (.clk(clk), .rst(rst), .clr(pe_clr), .w_load(w_load),
        .w_in(weight_1), .a_in(feed_r0), .sum_in('0),
        .a_out(pe_a[0]), .sum_out(pe_sum[0]), .sum_nxt(pe_nxt[0]));
    systolic_pe u_pe01 (.clk(clk), .rst(rst), .clr(pe_clr), .w_load(w_load),
        .w_in(weight_2), .a_in(pe_a[0]), .sum_in('0),
        .a_out(pe_a[1]), .sum_out(pe_sum[1]), .sum_nxt(pe_nxt[1]));
    systolic_pe u_pe10 (.clk(clk), .rst(rst), .clr(pe_clr), .w_load(w_load),
        .w_in(weight_3), .a_in(feed_r1), .sum_in(pe_sum[0]),
        .a_out(pe_a[2]), .sum_out(pe_sum[2]), .sum_nxt(pe_nxt[2]));
    systolic_pe u_pe11 (.clk(clk), .rst(rst), .clr(pe_clr), .w_load(w_load),
        .w_in(weight_4), .a_in(pe_a[2]), .sum_in(pe_sum[1]),
        .a_out(pe_a[3]), .sum_out(pe_sum[3]), .sum_nxt(pe_nxt[3]));

    // At the last step c00 has already left column 0 (held in col0_dly) and
    // c11 is still forming inside the bottom-right PE.
    assign res_d = {reduce(col0_dly), reduce(pe_sum[3]), reduce(pe_sum[2]), reduce(pe_nxt[3])};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = COMPUTE;
            COMPUTE: if (cnt == 2'd3) state_nxt = OUTPUT;
            OUTPUT:  if (accept && idx == 3'(OUT_BYTES - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            res_q     <= '0;
            col0_dly  <= '0;
            mat_q     <= '{default: '0};
        end else begin
            busy      <= (state_nxt == LOAD) || (state_nxt == COMPUTE) || (state_nxt == OUTPUT);
            out_valid <= (state_nxt == OUTPUT);
            done      <= (state_nxt == DONE);
            cnt       <= (state == COMPUTE) ? cnt + 2'd1 : '0;
            col0_dly  <= (state == COMPUTE) ? pe_sum[2] : '0;

            if (state == LOAD) begin
                mat_q[0] <= mat_1;
                mat_q[1] <= mat_2;
                mat_q[2] <= mat_3;
                mat_q[3] <= mat_4;
            end

            if (last_step)
                res_q <= res_d;

            if (state == COMPUTE)
                idx <= '0;
            else if (accept)
                idx <= idx + 3'd1;

            if (last_step)
                out_data <= pick(res_d, 3'd0);
            else if (state_nxt != OUTPUT)
                out_data <= '0;
            else if (accept)
                out_data <= pick(res_q, idx + 3'd1);
        end
    end

endmodule

// File: tb/tb_systolic_mmu.sv
// Self-checking bench for systolic_mmu: directed table, handshake corner cases
// and randomized operands against a plain-arithmetic matrix model.
`timescale 1ns/1ps
module tb_systolic_mmu;

    logic       clk = 1'b0;
    logic       rst, start, out_ready;
    logic [7:0] weight_1, weight_2, weight_3, weight_4;
    logic [7:0] mat_1, mat_2, mat_3, mat_4;
    logic [7:0] out_data;
    logic       out_valid, busy, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    systolic_mmu dut (
        .clk(clk), .rst(rst), .start(start),
        .weight_1(weight_1), .weight_2(weight_2), .weight_3(weight_3), .weight_4(weight_4),
        .mat_1(mat_1), .mat_2(mat_2), .mat_3(mat_3), .mat_4(mat_4),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] w;
        logic [63:0] exp;
        int          mode;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // C[i][j] = sum_k A[i][k]*W[k][j], then clamp or wrap to 16 bits.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] w);
        int am [4];
        int wm [4];
        int s;
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            am[k] = $signed(a[31-8*k -: 8]);
            wm[k] = $signed(w[31-8*k -: 8]);
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = am[2*i] * wm[j] + am[2*i+1] * wm[2+j];
`ifdef SATURATE_EN
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
`endif
                r[63-16*(2*i+j) -: 16] = 16'(s);
            end
        end
        return r;
    endfunction

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
    task automatic run_op(input logic [31:0] a, input logic [31:0] w, input int mode,
                          input bit poke, input bit abort,
                          output logic [63:0] got, output int first_valid, output int done_cyc);
        int cyc, nacc, k, last_acc;
        bit busy_ok, hold_ok, prev_stall, idle_ok;
        logic [7:0] prev_data;
        got = '0; nacc = 0; k = 0; last_acc = -10;
        first_valid = -1; done_cyc = -1;
        busy_ok = 1; hold_ok = 1; prev_stall = 0; idle_ok = 1; prev_data = '0;

        @(negedge clk);
        {mat_1, mat_2, mat_3, mat_4} = a;
        {weight_1, weight_2, weight_3, weight_4} = w;
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 300) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (abort && nacc == 3) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_clears_outputs", {52'd0, out_valid, busy, done, 1'b0, out_data}, 64'd0);
                return;
            end
            if (!busy) busy_ok = 0;
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (prev_stall && out_data !== prev_data) hold_ok = 0;
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (k % 3 == 0);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                k++;
                if (out_ready) begin
                    if (nacc < 8) got[63-8*nacc -: 8] = out_data;
                    nacc++;
                    last_acc = cyc;
                end
                prev_stall = !out_ready;
                prev_data  = out_data;
            end else begin
                prev_stall = 0;
                out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            if (poke && cyc == 3) start = 1'b1;
            if (poke && cyc == 4) start = 1'b0;
            if (poke && cyc == 8) mat_1 = ~mat_1;
            @(negedge clk);
            cyc++;
        end

        chk("no_timeout", 64'(done_cyc > 0), 64'd1);
        chk("busy_held", 64'(busy_ok), 64'd1);
        chk("data_held_in_stall", 64'(hold_ok), 64'd1);
        chk("accept_count", 64'(nacc), 64'd8);
        chk("done_after_last_accept", 64'(done_cyc), 64'(last_acc + 1));
        chk("done_cycle_flags", {62'd0, busy, out_valid}, 64'd0);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", 64'(done), 64'd0);
        if (poke) begin
            repeat (4) begin
                @(negedge clk);
                if (busy || out_valid || done) idle_ok = 0;
            end
            chk("no_second_run", 64'(idle_ok), 64'd1);
        end
    endtask

    logic [63:0] got, exp;
    logic [31:0] ra, rw;
    int fv, dc;

    initial begin
        tbl[0] = '{a: 32'h01020304, w: 32'h01000001, exp: 64'h0001_0002_0003_0004, mode: 0};
        tbl[1] = '{a: 32'hFF0203FC, w: 32'h05060708, exp: 64'h0009_000A_FFF3_FFF2, mode: 0};
`ifdef SATURATE_EN
        tbl[2] = '{a: 32'h80808080, w: 32'h80808080, exp: 64'h7FFF_7FFF_7FFF_7FFF, mode: 0};
`else
        tbl[2] = '{a: 32'h80808080, w: 32'h80808080, exp: 64'h8000_8000_8000_8000, mode: 0};
`endif
        tbl[3] = '{a: 32'hFF0203FC, w: 32'h05060708, exp: 64'h0009_000A_FFF3_FFF2, mode: 1};

        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        {mat_1, mat_2, mat_3, mat_4} = '0;
        {weight_1, weight_2, weight_3, weight_4} = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {52'd0, out_valid, busy, done, 1'b0, out_data}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_op(tbl[i].a, tbl[i].w, tbl[i].mode, 0, 0, got, fv, dc);
            chk($sformatf("table%0d_result", i), got, tbl[i].exp);
            if (tbl[i].mode == 0) begin
                chk($sformatf("table%0d_first_valid", i), 64'(fv), 64'd6);
                chk($sformatf("table%0d_done_cycle", i), 64'(dc), 64'd14);
            end
        end

        run_op(32'hFF0203FC, 32'h05060708, 0, 1, 0, got, fv, dc);
        chk("snapshot_result", got, 64'h0009_000A_FFF3_FFF2);

        run_op(32'hFF0203FC, 32'h05060708, 0, 0, 1, got, fv, dc);
        run_op(32'h01020304, 32'h01000001, 0, 0, 0, got, fv, dc);
        chk("after_abort_result", got, 64'h0001_0002_0003_0004);
        chk("after_abort_done_cycle", 64'(dc), 64'd14);

        for (int n = 0; n < 25; n++) begin
            ra = $urandom;
            rw = $urandom;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) ra[8*b +: 8] = 8'h80;
                if ($urandom_range(0, 7) == 0) rw[8*b +: 8] = 8'h80;
            end
            exp = model(ra, rw);
            run_op(ra, rw, 2, 0, 0, got, fv, dc);
            chk($sformatf("random%0d_result", n), got, exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
